// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serializes each word as a
// UART frame: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PENULT = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [WIDTH-1:0]  shift_reg;
    logic              parity_bit;

    // Every output is a register; the next bit's level is loaded into tx on the
    // same edge that ends the current bit, so tx only moves on bit boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        state      <= FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                FETCH: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg  <= fifo_data;
                    parity_bit <= ^fifo_data;
                    bit_cnt    <= '0;
                    baud_cnt   <= '0;
                    tx         <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    // Raised one edge early so the pulse lands on the final stop cycle.
                    if (baud_cnt == BAUD_PENULT) begin
                        frame_done <= 1'b1;
                    end
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: one instance without parity, one with,
// both at 4 clocks per bit, each fed by a small behavioural FIFO model.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int REC = 400;

    logic       clk;
    logic       rst;
    logic       en_n, en_p;
    logic       emp_n, emp_p;
    logic [7:0] dat_n, dat_p;
    logic       rd_en_n, rd_en_p;
    logic       tx_n, tx_p;
    logic       busy_n, busy_p;
    logic       done_n, done_p;

    int checks;
    int failures;

    logic [7:0] mem_n [0:63];
    logic [7:0] mem_p [0:63];
    int         wr_n, rd_n, wr_p, rd_p;
    logic [7:0] exp_n [$];
    logic [7:0] exp_p [$];

    logic rec_tx   [0:1][0:REC-1];
    logic rec_rd   [0:1][0:REC-1];
    logic rec_busy [0:1][0:REC-1];
    logic rec_done [0:1][0:REC-1];

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut (
        .clk(clk), .rst(rst), .enable(en_n), .fifo_empty(emp_n), .fifo_data(dat_n),
        .fifo_rd_en(rd_en_n), .tx(tx_n), .busy(busy_n), .frame_done(done_n)
    );

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .enable(en_p), .fifo_empty(emp_p), .fifo_data(dat_p),
        .fifo_rd_en(rd_en_p), .tx(tx_p), .busy(busy_p), .frame_done(done_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign emp_n = (wr_n == rd_n);
    assign emp_p = (wr_p == rd_p);

    // FIFO read port: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        if (rd_en_n) begin
            dat_n <= mem_n[rd_n[5:0]];
            rd_n  <= rd_n + 1;
        end
        if (rd_en_p) begin
            dat_p <= mem_p[rd_p[5:0]];
            rd_p  <= rd_p + 1;
        end
    end

    task automatic push_word(input int sel, input logic [7:0] w);
        if (sel == 0) begin
            mem_n[wr_n[5:0]] = w;
            wr_n = wr_n + 1;
            exp_n.push_back(w);
        end else begin
            mem_p[wr_p[5:0]] = w;
            wr_p = wr_p + 1;
            exp_p.push_back(w);
        end
    endtask

    task automatic pop_expected(input int sel, output logic [7:0] w);
        w = 8'hxx;
        if (sel == 0 && exp_n.size() > 0) w = exp_n.pop_front();
        if (sel == 1 && exp_p.size() > 0) w = exp_p.pop_front();
    endtask

    task automatic record(input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            @(negedge clk);
            rec_tx[0][i]   = tx_n;    rec_tx[1][i]   = tx_p;
            rec_rd[0][i]   = rd_en_n; rec_rd[1][i]   = rd_en_p;
            rec_busy[0][i] = busy_n;  rec_busy[1][i] = busy_p;
            rec_done[0][i] = done_n;  rec_done[1][i] = done_p;
        end
    endtask

    function automatic int find_start(input int sel, input int from, input int to);
        for (int i = from; i < to; i++)
            if (rec_tx[sel][i] === 1'b0) return i;
        return -1;
    endfunction

    function automatic int count_rd(input int sel, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) if (rec_rd[sel][i] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_done(input int sel, input int from, input int to);
        int c = 0;
        for (int i = from; i < to; i++) if (rec_done[sel][i] === 1'b1) c++;
        return c;
    endfunction

    // Samples every cycle of every bit of a recorded frame starting at index s.
    task automatic decode_frame(input int sel, input int s, input int par,
                                output logic [7:0] w, output logic p,
                                output logic framing_ok, output logic stable);
        logic lvl;
        w = '0; p = 1'b0; framing_ok = 1'b1; stable = 1'b1;
        for (int k = 0; k < 10 + par; k++) begin
            lvl = rec_tx[sel][s + k*CPB];
            for (int j = 1; j < CPB; j++)
                if (rec_tx[sel][s + k*CPB + j] !== lvl) stable = 1'b0;
            if (k == 0) begin
                if (lvl !== 1'b0) framing_ok = 1'b0;
            end else if (k <= 8) begin
                w[k-1] = lvl;
            end else if (k == 9 && par != 0) begin
                p = lvl;
            end else begin
                if (lvl !== 1'b1) framing_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        logic bad;
        rst = 1'b1; en_n = 1'b1; en_p = 1'b1;
        push_word(0, 8'hA5);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_n !== 1'b1 || busy_n !== 1'b0 || rd_en_n !== 1'b0 || done_n !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: tx=%b busy=%b rd_en=%b done=%b, required 1 0 0 0", tx_n, busy_n, rd_en_n, done_n);
        end
        checks++;
        if ({tx_p, busy_p, rd_en_p, done_p} !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL reset_outputs_parity: got %b required 1000", {tx_p, busy_p, rd_en_p, done_p});
        end
    endtask

    task automatic test_single;
        int s;
        logic [7:0] w, w_exp;
        logic p, fr, st;
        rst = 1'b0;
        record(0, 60);
        s = find_start(0, 0, 20);
        checks++;
        if (s !== 2) begin
            failures++;
            $display("[TB] FAIL single_start_index: got %0d required 2", s);
            return;
        end
        checks++;
        if (rec_rd[0][0] !== 1'b1 || count_rd(0, 0, 60) !== 1) begin
            failures++;
            $display("[TB] FAIL single_rd_pulse: first=%b count=%0d required 1 and 1", rec_rd[0][0], count_rd(0, 0, 60));
        end
        decode_frame(0, s, 0, w, p, fr, st);
        pop_expected(0, w_exp);
        checks++;
        if (w !== w_exp || fr !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_frame: data=%h framing=%b stable=%b required %h 1 1", w, fr, st, w_exp);
        end
        checks++;
        if (rec_done[0][s+39] !== 1'b1 || count_done(0, 0, 60) !== 1) begin
            failures++;
            $display("[TB] FAIL single_frame_done: at_end=%b count=%0d required 1 and 1", rec_done[0][s+39], count_done(0, 0, 60));
        end
        checks++;
        if (rec_busy[0][s+39] !== 1'b1 || rec_busy[0][s+40] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_busy_fall: last=%b next=%b required 1 0", rec_busy[0][s+39], rec_busy[0][s+40]);
        end
    endtask

    task automatic test_parity;
        int s1, s2;
        logic [7:0] w, w_exp;
        logic p, fr, st;
        push_word(1, 8'h07);
        push_word(1, 8'h03);
        record(0, 110);
        s1 = find_start(1, 0, 20);
        checks++;
        if (s1 < 0) begin
            failures++;
            $display("[TB] FAIL parity_first_start: got none required a start bit");
            return;
        end
        decode_frame(1, s1, 1, w, p, fr, st);
        pop_expected(1, w_exp);
        checks++;
        if (w !== w_exp || p !== ^w_exp || fr !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("[TB] FAIL parity_frame_07: data=%h par=%b framing=%b stable=%b required %h %b 1 1", w, p, fr, st, w_exp, ^w_exp);
        end
        checks++;
        if (rec_done[1][s1+43] !== 1'b1 || rec_done[1][s1+42] !== 1'b0) begin
            failures++;
            $display("[TB] FAIL parity_frame_len: done@43=%b done@42=%b required 1 0", rec_done[1][s1+43], rec_done[1][s1+42]);
        end
        s2 = find_start(1, s1 + 44, 110);
        checks++;
        if (s2 !== s1 + 47) begin
            failures++;
            $display("[TB] FAIL parity_second_start: got %0d required %0d", s2, s1 + 47);
            return;
        end
        decode_frame(1, s2, 1, w, p, fr, st);
        pop_expected(1, w_exp);
        checks++;
        if (w !== w_exp || p !== ^w_exp || fr !== 1'b1) begin
            failures++;
            $display("[TB] FAIL parity_frame_03: data=%h par=%b framing=%b required %h %b 1", w, p, fr, w_exp, ^w_exp);
        end
    endtask

    task automatic test_back_to_back;
        int s1, s2;
        logic [7:0] w, w_exp;
        logic p, fr, st;
        push_word(0, 8'h01);
        push_word(0, 8'h80);
        record(0, 100);
        s1 = find_start(0, 0, 20);
        s2 = (s1 < 0) ? -1 : find_start(0, s1 + 40, 100);
        checks++;
        if (s1 < 0 || s2 !== s1 + 43) begin
            failures++;
            $display("[TB] FAIL b2b_gap: first=%0d second=%0d required gap of 3 idle-high cycles", s1, s2);
            return;
        end
        checks++;
        if (count_rd(0, 0, 100) !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_rd_count: got %0d required 2", count_rd(0, 0, 100));
        end
        decode_frame(0, s1, 0, w, p, fr, st);
        pop_expected(0, w_exp);
        checks++;
        if (w !== w_exp || fr !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first_word: data=%h required %h", w, w_exp);
        end
        decode_frame(0, s2, 0, w, p, fr, st);
        pop_expected(0, w_exp);
        checks++;
        if (w !== w_exp || fr !== 1'b1 || st !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_second_word: data=%h required %h", w, w_exp);
        end
    endtask

    task automatic test_enable_gating;
        int s, high;
        logic [7:0] w, w_exp;
        logic p, fr, st;
        en_n = 1'b0;
        push_word(0, 8'h3C);
        push_word(0, 8'h55);
        record(0, 50);
        high = 0;
        for (int i = 0; i < 50; i++) if (rec_tx[0][i] === 1'b1) high++;
        checks++;
        if (count_rd(0, 0, 50) !== 0 || high !== 50) begin
            failures++;
            $display("[TB] FAIL gate_idle: rd=%0d high_cycles=%0d required 0 and 50", count_rd(0, 0, 50), high);
        end
        en_n = 1'b1;
        record(50, 20);
        en_n = 1'b0;
        record(70, 60);
        s = find_start(0, 50, 70);
        checks++;
        if (s < 0) begin
            failures++;
            $display("[TB] FAIL gate_start: got none required a start bit");
            return;
        end
        decode_frame(0, s, 0, w, p, fr, st);
        pop_expected(0, w_exp);
        checks++;
        if (w !== w_exp || fr !== 1'b1 || st !== 1'b1 || rec_done[0][s+39] !== 1'b1) begin
            failures++;
            $display("[TB] FAIL gate_frame: data=%h done=%b required %h 1", w, rec_done[0][s+39], w_exp);
        end
        checks++;
        if (count_rd(0, 50, 130) !== 1 || (wr_n - rd_n) !== 1) begin
            failures++;
            $display("[TB] FAIL gate_no_refetch: rd=%0d left=%0d required 1 and 1", count_rd(0, 50, 130), wr_n - rd_n);
        end
    endtask

    task automatic test_reset_mid_frame;
        int s, waited;
        logic bad;
        logic [7:0] w, w_exp;
        logic p, fr, st;
        en_n = 1'b1;
        waited = 0;
        while (tx_n !== 1'b0 && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_start: tx=%b required 0 within 30 cycles", tx_n);
            return;
        end
        repeat (21) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (tx_n !== 1'b1 || busy_n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_async: tx=%b busy=%b required 1 0", tx_n, busy_n);
        end
        pop_expected(0, w_exp);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done_n !== 1'b0 || tx_n !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_no_done: saw frame_done or tx low during reset, required neither");
        end
        push_word(0, 8'h99);
        rst = 1'b0;
        record(0, 60);
        s = find_start(0, 0, 20);
        checks++;
        if (s !== 2) begin
            failures++;
            $display("[TB] FAIL midreset_restart: start=%0d required 2", s);
            return;
        end
        decode_frame(0, s, 0, w, p, fr, st);
        pop_expected(0, w_exp);
        checks++;
        if (w !== w_exp || fr !== 1'b1 || st !== 1'b1 || count_done(0, 0, 60) !== 1) begin
            failures++;
            $display("[TB] FAIL midreset_fresh_frame: data=%h done_count=%0d required %h 1", w, count_done(0, 0, 60), w_exp);
        end
        checks++;
        if (rd_n > wr_n || rd_p > wr_p) begin
            failures++;
            $display("[TB] FAIL fifo_underflow: pops=%0d/%0d pushes=%0d/%0d required pops <= pushes", rd_n, rd_p, wr_n, wr_p);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        wr_n = 0; rd_n = 0; wr_p = 0; rd_p = 0;
        dat_n = '0; dat_p = '0;
        rst = 1'b1; en_n = 1'b0; en_p = 1'b0;
        test_reset();
        test_single();
        test_parity();
        test_back_to_back();
        test_enable_gating();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the team's simple synchronous FIFO: pops one word at a time through the FIFO read port and serializes it as an asynchronous UART frame on tx.
- Frame order: start bit, WIDTH data bits LSB first, optional even parity bit, one stop bit.
- Sits between the FIFO's data_out/empty/rd_en interface and the chip-level serial pin.

Parameters:
- WIDTH, 8, data bits per frame; equals FIFO WIDTH.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting a new frame; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WIDTH  FIFO data_out, valid one cycle after fifo_rd_en.
- fifo_rd_en  output  1  FIFO pop strobe, one-cycle pulse per word.
- tx  output  1  serial line, idle high.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (async): state=IDLE; tx=1, fifo_rd_en=0, busy=0, frame_done=0; bit and baud counters=0; shift register=0.
- All outputs are Moore, decoded from registered state and registered tx.
- IDLE: tx=1. If enable=1 and fifo_empty=0 at a clock edge, go to FETCH. Otherwise stay.
- FETCH (1 cycle): fifo_rd_en=1. Always go to LOAD. No re-check of fifo_empty.
- LOAD (1 cycle): capture fifo_data into the shift register. Compute parity = XOR of all data bits. Go to START.
- START: tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA: emit shift register bits LSB first, each for CLKS_PER_BIT cycles. After bit WIDTH-1, go to PARITY if PARITY_EN=1, else to STOP.
- PARITY: tx=parity for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle. Then go to IDLE.
- Baud counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1. Cleared on every bit transition.
- Bit counter: width $clog2(WIDTH+1). Cleared in LOAD.
- Frame length: (2+WIDTH+PARITY_EN)*CLKS_PER_BIT cycles, from the first START cycle to the last STOP cycle inclusive.
- Back-to-back frames: exactly 3 tx-high cycles (IDLE, FETCH, LOAD) between the last STOP cycle and the next START cycle.
- tx changes only on bit boundaries; no glitches within a bit.
- enable deasserted mid-frame: the current frame completes unchanged and no further FETCH occurs.
- fifo_empty toggling outside IDLE: ignored.
- Exactly one fifo_rd_en pulse per transmitted frame. Never asserted in any other state, so the FIFO is never popped while empty given a correct empty flag.
- Reset mid-frame: tx returns to 1 immediately (async). The partial frame is abandoned and the word is lost; no frame_done is generated.
- After reset release, normal operation restarts from IDLE.

Test Plan:
- Reset check: assert rst, hold fifo_empty=0 and enable=1 -> tx=1, busy=0, fifo_rd_en=0, frame_done=0 throughout reset.
- Single word, CLKS_PER_BIT=4, PARITY_EN=0, word 0xA5 -> exactly one fifo_rd_en pulse. tx = 0 then 1,0,1,0,0,1,0,1 then 1, each held 4 cycles (40 cycles total). frame_done pulses on cycle 40. busy falls the next cycle.
- Parity, PARITY_EN=1, word 0x07 -> parity bit = 1 after data bits 1,1,1,0,0,0,0,0. Word 0x03 -> parity bit = 0. Frame is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: FIFO holds 0x01 and 0x80, enable=1 -> two fifo_rd_en pulses and two frames in order. Exactly 3 tx-high cycles between the first STOP end and the second START.
- Enable gating: enable=0 with fifo_empty=0 for 50 cycles -> no fifo_rd_en, tx=1. Then drop enable during DATA of the next frame -> frame completes, frame_done pulses, no second fetch.
- Reset mid-DATA (after bit 3): tx=1 at once, busy=0, no frame_done. Release reset with FIFO non-empty -> a fresh complete frame of the next word is sent.
